multicycle_control_fsm: RTL and testbench

- Main control state machine for the multicycle variant of the MIPS core, which uses one shared memory port, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Replaces the single-cycle opcode decoder. It steps each instruction through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and halts (traps) on illegal instructions or memory timeouts.

---
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
//
// Memory-port handshake between the multicycle control FSM and the shared
// instruction/data memory.
//
//   MemReady : memory completes the current access this cycle (memory -> FSM)
//   MemRead  : read request                                   (FSM -> memory)
//   MemWrite : write request                                  (FSM -> memory)
//   IorD     : address select, 0 = PC, 1 = ALUOut             (FSM -> memory)
//
// The FSM connects through the master modport; the memory (or a testbench
// standing in for it) uses the slave modport.
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if;
  logic MemReady;
  logic MemRead;
  logic MemWrite;
  logic IorD;

  modport master (
    input  MemReady,
    output MemRead,
    output MemWrite,
    output IorD
  );

  modport slave (
    output MemReady,
    input  MemRead,
    input  MemWrite,
    input  IorD
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control state machine of the multicycle MIPS core. One shared memory
// port, one ALU and the IR/MDR/A/B/ALUOut holding registers are sequenced
// through fetch, decode, execute, memory and write-back. Memory states stall
// on the MemReady handshake; an illegal instruction or a memory access that
// stalls for MEM_TIMEOUT consecutive cycles sends the machine to TRAP, which
// only reset leaves.
//
// Parameters
//   MEM_TIMEOUT : consecutive stall cycles allowed in a memory state before
//                 trapping; 0 disables the timeout.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   mem        : memory handshake (MemReady in; MemRead, MemWrite, IorD out)
//   OP, Funct  : IR[31:26] and IR[5:0]
//   Zero       : ALU zero flag
//   PCWrite    : PC load enable
//   PCSource   : 00 ALU, 01 ALUOut, 10 jump target, 11 A register
//   IRWrite    : instruction register load enable
//   RegDst     : 00 rt, 01 rd, 10 $31
//   WBSel      : 00 ALUOut, 01 MDR, 10 PC, 11 {imm, 16'b0}
//   RegWrite   : register file write enable
//   ALUSrcA    : 0 PC, 1 A register
//   ALUSrcB    : 00 B, 01 constant 4, 10 sext imm, 11 sext imm << 2
//   ALUOp      : 000 add, 001 sub, 010 R-type, 011 or, 100 and
//   InstrDone  : pulse on the final cycle of each instruction
//   Halted     : machine is in TRAP
//   Cause      : 00 none, 01 illegal instruction, 10 memory timeout
//   State      : current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  multicycle_control_fsm_if.master        mem,
  input  logic [5:0]                      OP,
  input  logic [5:0]                      Funct,
  input  logic                            Zero,
  output logic                            PCWrite,
  output logic [1:0]                      PCSource,
  output logic                            IRWrite,
  output logic [1:0]                      RegDst,
  output logic [1:0]                      WBSel,
  output logic                            RegWrite,
  output logic                            ALUSrcA,
  output logic [1:0]                      ALUSrcB,
  output logic [2:0]                      ALUOp,
  output logic                            InstrDone,
  output logic                            Halted,
  output logic [1:0]                      Cause,
  output logic [3:0]                      State
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    LUI      = 4'd14,
    TRAP     = 4'd15
  } stateT;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } causeT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RTY  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;

  // The trap fires on the stall cycle that would bring the count to
  // MEM_TIMEOUT, i.e. while the registered count is MEM_TIMEOUT-1. The counter
  // therefore never needs to hold more than MEM_TIMEOUT-1; it saturates when
  // the timeout is disabled.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  stateT           state, nextState;
  causeT           causeQ, causeNext;
  logic [CNT_W-1:0] stallCnt, stallNext;

  logic            inStallState;
  logic            timeoutHit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      causeQ   <= CAUSE_NONE;
      stallCnt <= '0;
    end else begin
      state    <= nextState;
      causeQ   <= causeNext;
      stallCnt <= stallNext;
    end
  end

  // R-type functions the datapath implements; JR is decoded separately.
  function automatic logic isLegalRFunct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLL) ||
           (fn == FN_SRL);
  endfunction

  assign inStallState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeoutHit   = (MEM_TIMEOUT > 0) && inStallState && !mem.MemReady &&
                        (stallCnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    causeNext = causeQ;

    case (state)
      FETCH: begin
        if (mem.MemReady) begin
          nextState = DECODE;
        end else if (timeoutHit) begin
          nextState = TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end

      DECODE: begin
        case (OP)
          OP_RTYPE: begin
            if (Funct == FN_JR) begin
              nextState = JR;
            end else if (isLegalRFunct(Funct)) begin
              nextState = EXEC_R;
            end else begin
              nextState = TRAP;
              causeNext = CAUSE_ILLEGAL;
            end
          end
          OP_LW, OP_SW:             nextState = MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = EXEC_I;
          OP_BEQ, OP_BNE:           nextState = BRANCH;
          OP_J:                     nextState = JUMP;
          OP_JAL:                   nextState = JAL;
          OP_LUI:                   nextState = LUI;
          default: begin
            nextState = TRAP;
            causeNext = CAUSE_ILLEGAL;
          end
        endcase
      end

      MEM_ADDR: nextState = (OP == OP_LW) ? MEM_RD : MEM_WR;

      MEM_RD: begin
        if (mem.MemReady) begin
          nextState = MEM_WB;
        end else if (timeoutHit) begin
          nextState = TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end

      MEM_WR: begin
        if (mem.MemReady) begin
          nextState = FETCH;
        end else if (timeoutHit) begin
          nextState = TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end

      EXEC_R:  nextState = R_WB;
      EXEC_I:  nextState = I_WB;

      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR, LUI: nextState = FETCH;

      TRAP:    nextState = TRAP;

      default: nextState = TRAP;
    endcase
  end

  // Stall counter: counts consecutive not-ready cycles within one memory
  // state; any state change or a completed access restarts it.
  always_comb begin
    stallNext = '0;
    if ((nextState == state) && inStallState && !mem.MemReady) begin
      stallNext = (stallCnt == CNT_MAX) ? stallCnt : stallCnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore outputs plus the few documented input dependencies)
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite      = 1'b0;
    PCSource     = 2'b00;
    mem.IorD     = 1'b0;
    mem.MemRead  = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 2'b00;
    WBSel        = 2'b00;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = ALU_ADD;
    Halted       = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 goes straight back into PC on the same cycle the IR loads.
        mem.MemRead = 1'b1;
        ALUSrcB     = 2'b01;
        IRWrite     = mem.MemReady;
        PCWrite     = mem.MemReady;
      end

      DECODE: begin
        // Precompute the branch target into ALUOut while registers are read.
        ALUSrcB = 2'b11;
      end

      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end

      MEM_RD: begin
        mem.IorD    = 1'b1;
        mem.MemRead = 1'b1;
      end

      MEM_WB: begin
        WBSel    = 2'b01;
        RegWrite = 1'b1;
      end

      MEM_WR: begin
        mem.IorD     = 1'b1;
        mem.MemWrite = 1'b1;
      end

      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTY;
      end

      R_WB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end

      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          OP_ORI:  ALUOp = ALU_OR;
          OP_ANDI: ALUOp = ALU_AND;
          default: ALUOp = ALU_ADD;
        endcase
      end

      I_WB: begin
        RegWrite = 1'b1;
      end

      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = (OP == OP_BEQ) ? Zero : ~Zero;
      end

      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end

      JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        RegDst   = 2'b10;
        WBSel    = 2'b10;
        RegWrite = 1'b1;
      end

      JR: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end

      LUI: begin
        WBSel    = 2'b11;
        RegWrite = 1'b1;
      end

      TRAP: begin
        Halted = 1'b1;
      end

      default: ;
    endcase

    // An instruction interrupted by reset must not update any architectural
    // state in the reset cycle.
    if (!reset) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      mem.MemRead  = 1'b0;
      mem.MemWrite = 1'b0;
      RegWrite     = 1'b0;
    end
  end

  assign InstrDone = (state != FETCH) && (nextState == FETCH);
  assign Cause     = causeQ;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm. Each scenario task builds a list
// of per-cycle steps (inputs plus hand-computed expected outputs) and walks it
// one clock at a time, comparing the packed output vector against the
// expectation. Inputs change 1 time unit after the rising edge and outputs are
// sampled 1 time unit later, well clear of the next edge.
//
// Packed vector layout (MSB..LSB):
//   PCWrite, PCSource[1:0], IorD, MemRead, MemWrite, IRWrite, RegDst[1:0],
//   WBSel[1:0], RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], InstrDone,
//   Halted, Cause[1:0], State[3:0]
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;

  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] WBSel;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       InstrDone;
  logic       Halted;
  logic [1:0] Cause;
  logic [3:0] State;

  multicycle_control_fsm_if memBus ();

  multicycle_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (memBus),
    .OP        (OP),
    .Funct     (Funct),
    .Zero      (Zero),
    .PCWrite   (PCWrite),
    .PCSource  (PCSource),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .WBSel     (WBSel),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .InstrDone (InstrDone),
    .Halted    (Halted),
    .Cause     (Cause),
    .State     (State)
  );

  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {PCWrite, PCSource, memBus.IorD, memBus.MemRead, memBus.MemWrite,
                IRWrite, RegDst, WBSel, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                InstrDone, Halted, Cause, State};

  // Full compare, and one that ignores InstrDone for cycles where reset is low.
  localparam logic [25:0] FULL   = 26'h3FF_FFFF;
  localparam logic [25:0] NODONE = 26'h3FF_FF7F;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [25:0] exp;
    logic [25:0] mask;
  } step_t;

  int nChecks = 0;
  int nPass   = 0;

  function automatic logic [25:0] pk(
    input int pcw, input int pcs, input int iord, input int mr, input int mw,
    input int irw, input int rd, input int wb, input int rw, input int sa,
    input int sb, input int aop, input int done, input int halt,
    input int cause, input int st);
    return {pcw[0], pcs[1:0], iord[0], mr[0], mw[0], irw[0], rd[1:0], wb[1:0],
            rw[0], sa[0], sb[1:0], aop[2:0], done[0], halt[0], cause[1:0],
            st[3:0]};
  endfunction

  function automatic step_t mk(input int rst, input int rdy, input int zero,
                               input int op, input int fn,
                               input logic [25:0] exp, input logic [25:0] mask);
    step_t s;
    s.rst  = rst[0];
    s.rdy  = rdy[0];
    s.zero = zero[0];
    s.op   = op[5:0];
    s.fn   = fn[5:0];
    s.exp  = exp;
    s.mask = mask;
    return s;
  endfunction

  // Hand-derived output vectors for the states used by several scenarios.
  logic [25:0] vFetchRdy, vFetchStall, vFetchRst, vDecode, vExecR, vRWb;
  logic [25:0] vMemAddr, vMemRd, vMemWb, vMemWr, vMemWrDone;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    step_t q[$];
    // Two cycles held in reset with MemReady high: FETCH, enables forced off.
    q.push_back(mk(0, 1, 0, 'h00, 'h20, vFetchRst, NODONE));
    q.push_back(mk(0, 1, 0, 'h00, 'h20, vFetchRst, NODONE));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_reset step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_r_type();
    step_t q[$];
    // add then sub, MemReady tied high: 0,1,6,7 each, 4 cycles per instruction.
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vExecR,    FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vRWb,      FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h22, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h22, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h22, vExecR,    FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h22, vRWb,      FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_r_type step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_store();
    step_t q[$];
    // lw: 3 stall cycles in MEM_RD then ready -> 4 cycles in state 3.
    q.push_back(mk(1, 1, 0, 'h23, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h23, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h23, 0, vMemAddr,  FULL));
    q.push_back(mk(1, 0, 0, 'h23, 0, vMemRd,    FULL));
    q.push_back(mk(1, 0, 0, 'h23, 0, vMemRd,    FULL));
    q.push_back(mk(1, 0, 0, 'h23, 0, vMemRd,    FULL));
    q.push_back(mk(1, 1, 0, 'h23, 0, vMemRd,    FULL));
    q.push_back(mk(1, 0, 0, 'h23, 0, vMemWb,    FULL));
    // sw: MemWrite held across a 2-cycle stall, done on the ready cycle.
    q.push_back(mk(1, 1, 0, 'h2B, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vMemAddr,  FULL));
    q.push_back(mk(1, 0, 0, 'h2B, 0, vMemWr,    FULL));
    q.push_back(mk(1, 0, 0, 'h2B, 0, vMemWr,    FULL));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vMemWrDone, FULL));
    q.push_back(mk(1, 0, 0, 'h2B, 0, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_load_store step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    step_t q[$];
    logic [25:0] vBrTaken, vBrNot;
    vBrTaken = pk(1,1,0,0,0,0, 0,0,0, 1,0,1, 1,0,0,10);
    vBrNot   = pk(0,1,0,0,0,0, 0,0,0, 1,0,1, 1,0,0,10);
    // beq Z=1 taken, bne Z=1 not taken, bne Z=0 taken, beq Z=0 not taken.
    q.push_back(mk(1, 1, 1, 'h04, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 1, 'h04, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 1, 'h04, 0, vBrTaken,  FULL));
    q.push_back(mk(1, 1, 1, 'h05, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 1, 'h05, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 1, 'h05, 0, vBrNot,    FULL));
    q.push_back(mk(1, 1, 0, 'h05, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h05, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h05, 0, vBrTaken,  FULL));
    q.push_back(mk(1, 1, 0, 'h04, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h04, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h04, 0, vBrNot,    FULL));
    q.push_back(mk(1, 0, 0, 'h04, 0, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_branch step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jumps();
    step_t q[$];
    q.push_back(mk(1, 1, 0, 'h02, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h02, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h02, 0, pk(1,2,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,11), FULL));
    q.push_back(mk(1, 1, 0, 'h03, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h03, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h03, 0, pk(1,2,0,0,0,0, 2,2,1, 0,0,0, 1,0,0,12), FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h08, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h08, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h08, pk(1,3,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,13), FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h08, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_jumps step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_immediate();
    step_t q[$];
    logic [25:0] vIWb;
    vIWb = pk(0,0,0,0,0,0, 0,0,1, 0,0,0, 1,0,0,9);
    // ori, andi, addi each pick their own ALUOp; lui writes {imm,16'b0}.
    q.push_back(mk(1, 1, 0, 'h0D, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h0D, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h0D, 0, pk(0,0,0,0,0,0, 0,0,0, 1,2,3, 0,0,0,8), FULL));
    q.push_back(mk(1, 1, 0, 'h0D, 0, vIWb,      FULL));
    q.push_back(mk(1, 1, 0, 'h0C, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h0C, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h0C, 0, pk(0,0,0,0,0,0, 0,0,0, 1,2,4, 0,0,0,8), FULL));
    q.push_back(mk(1, 1, 0, 'h0C, 0, vIWb,      FULL));
    q.push_back(mk(1, 1, 0, 'h08, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h08, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h08, 0, pk(0,0,0,0,0,0, 0,0,0, 1,2,0, 0,0,0,8), FULL));
    q.push_back(mk(1, 1, 0, 'h08, 0, vIWb,      FULL));
    q.push_back(mk(1, 1, 0, 'h0F, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h0F, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h0F, 0, pk(0,0,0,0,0,0, 0,3,1, 0,0,0, 1,0,0,14), FULL));
    q.push_back(mk(1, 0, 0, 'h0F, 0, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_immediate step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal();
    step_t q[$];
    logic [25:0] vTrapIll;
    vTrapIll = pk(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,1,15);
    // OP=0x3F traps and stays halted for 20 cycles whatever MemReady/Zero do.
    q.push_back(mk(1, 1, 0, 'h3F, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h3F, 0, vDecode,   FULL));
    for (int k = 0; k < 20; k++)
      q.push_back(mk(1, k % 2, (k / 2) % 2, 'h3F, 0, vTrapIll, FULL));
    // Reset leaves TRAP and clears Cause.
    q.push_back(mk(0, 1, 0, 'h3F, 0, vTrapIll, NODONE));
    q.push_back(mk(1, 0, 0, 'h00, 'h01, vFetchStall, FULL));
    // R-type with unsupported Funct 0x01 traps too.
    q.push_back(mk(1, 1, 0, 'h00, 'h01, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h01, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h01, vTrapIll,  FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h01, vTrapIll,  FULL));
    q.push_back(mk(0, 1, 0, 'h00, 'h01, vTrapIll,  NODONE));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_illegal step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    step_t q[$];
    logic [25:0] vTrapTo;
    vTrapTo = pk(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,2,15);
    // Fresh stall counter, then 15 not-ready FETCH cycles -> TRAP, Cause=10.
    q.push_back(mk(0, 0, 0, 'h00, 'h20, vFetchRst, NODONE));
    for (int k = 0; k < 15; k++)
      q.push_back(mk(1, 0, 0, 'h00, 'h20, vFetchStall, FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vTrapTo, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vTrapTo, FULL));
    q.push_back(mk(0, 0, 0, 'h00, 'h20, vTrapTo, NODONE));
    // 14 not-ready cycles, ready on the 15th: the access wins, no trap.
    for (int k = 0; k < 14; k++)
      q.push_back(mk(1, 0, 0, 'h00, 'h20, vFetchStall, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vFetchRdy, FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vDecode,   FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vExecR,    FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vRWb,      FULL));
    q.push_back(mk(1, 0, 0, 'h00, 'h20, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_timeout step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    step_t q[$];
    // Reset during R_WB suppresses RegWrite; during MEM_WR suppresses MemWrite.
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h00, 'h20, vExecR,    FULL));
    q.push_back(mk(0, 1, 0, 'h00, 'h20, pk(0,0,0,0,0,0, 1,0,0, 0,0,0, 1,0,0,7), NODONE));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vFetchRdy, FULL));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vDecode,   FULL));
    q.push_back(mk(1, 1, 0, 'h2B, 0, vMemAddr,  FULL));
    q.push_back(mk(0, 1, 0, 'h2B, 0, pk(0,0,1,0,0,0, 0,0,0, 0,0,0, 1,0,0,5), NODONE));
    q.push_back(mk(1, 0, 0, 'h2B, 0, vFetchStall, FULL));
    foreach (q[i]) begin
      reset = q[i].rst; memBus.MemReady = q[i].rdy; Zero = q[i].zero;
      OP = q[i].op; Funct = q[i].fn;
      #1;
      nChecks++;
      if ((obs & q[i].mask) !== (q[i].exp & q[i].mask))
        $display("FAIL test_mid_reset step %0d: outputs %h required %h", i,
                 obs & q[i].mask, q[i].exp & q[i].mask);
      else nPass++;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    vFetchRdy   = pk(1,0,0,1,0,1, 0,0,0, 0,1,0, 0,0,0, 0);
    vFetchStall = pk(0,0,0,1,0,0, 0,0,0, 0,1,0, 0,0,0, 0);
    vFetchRst   = pk(0,0,0,0,0,0, 0,0,0, 0,1,0, 0,0,0, 0);
    vDecode     = pk(0,0,0,0,0,0, 0,0,0, 0,3,0, 0,0,0, 1);
    vExecR      = pk(0,0,0,0,0,0, 0,0,0, 1,0,2, 0,0,0, 6);
    vRWb        = pk(0,0,0,0,0,0, 1,0,1, 0,0,0, 1,0,0, 7);
    vMemAddr    = pk(0,0,0,0,0,0, 0,0,0, 1,2,0, 0,0,0, 2);
    vMemRd      = pk(0,0,1,1,0,0, 0,0,0, 0,0,0, 0,0,0, 3);
    vMemWb      = pk(0,0,0,0,0,0, 0,1,1, 0,0,0, 1,0,0, 4);
    vMemWr      = pk(0,0,1,0,1,0, 0,0,0, 0,0,0, 0,0,0, 5);
    vMemWrDone  = pk(0,0,1,0,1,0, 0,0,0, 0,0,0, 1,0,0, 5);

    reset           = 1'b0;
    memBus.MemReady = 1'b1;
    Zero            = 1'b0;
    OP              = 6'h00;
    Funct           = 6'h20;
    cyc();

    test_reset();
    test_r_type();
    test_load_store();
    test_branch();
    test_jumps();
    test_immediate();
    test_illegal();
    test_timeout();
    test_mid_reset();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
